// File: rtl/display_scan_mux_pkg.sv
// display_scan_mux shared types and constants.
// Digit-code select and enable helpers used by the scan FSM.
package display_pkg;

  localparam int N_DIGITS = 4;
  localparam int CODE_W   = 3;
  localparam logic [N_DIGITS-1:0] BITS_OFF = 4'b1111;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_e;

  function automatic logic [CODE_W-1:0] code_sel(
    input logic [11:0] d,
    input logic [1:0]  i
  );
    logic [CODE_W-1:0] c;
    unique case (i)
      2'd0:    c = d[2:0];
      2'd1:    c = d[5:3];
      2'd2:    c = d[8:6];
      default: c = d[11:9];
    endcase
    return c;
  endfunction

  function automatic logic [N_DIGITS-1:0] bits_on(
    input logic [1:0] i
  );
    return ~(4'b0001 << i);
  endfunction

endpackage

// File: rtl/display_scan_mux_if.sv
// display_scan_mux data/display bundle.
// Bench drives the master side; the scan mux is the slave.
interface display_scan_mux_if;
  logic [11:0] DATA_IN;
  logic        LOAD;
  logic [2:0]  CODE_OUT;
  logic [3:0]  BITS;
  logic        PENDING;
  logic        FRAME_TICK;

  modport master (
    output DATA_IN, LOAD,
    input  CODE_OUT, BITS, PENDING, FRAME_TICK
  );

  modport slave (
    input  DATA_IN, LOAD,
    output CODE_OUT, BITS, PENDING, FRAME_TICK
  );
endinterface

// File: rtl/display_scan_mux_prescaler.sv
// scan_prescaler: per-slot cycle counter.
// Flags last cycle of a slot and last blanked cycle.
module scan_prescaler #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en_i,
  output logic slot_end_o,
  output logic blank_end_o
);

  localparam int W = $clog2(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);
  localparam logic [W-1:0] BEND = W'(BLANK_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign slot_end_o  = (cnt_q == LAST);
  assign blank_end_o = (cnt_q == BEND);

  // next count: wrap at slot end, hold until enabled
  always_comb begin
    cnt_d = cnt_q;
    if (en_i)
      cnt_d = slot_end_o ? '0 : cnt_q + W'(1);
  end

  // counter register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_scan_mux.sv
// display_scan_mux: 4-digit 7-seg scan with frame-aligned double buffer.
// Define SCAN_BLANK_EN to blank the first BLANK_CYCLES cycles of each slot.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input logic CLK,
  input logic RST_N,
  display_scan_mux_if.slave bus
);

  logic        slot_end, blank_end;
  logic        run_q;
  state_e      state_q, state_d;
  logic [1:0]  dig_q, dig_d;
  logic [11:0] disp_q, disp_d;
  logic [11:0] pend_q;
  logic        pend_v;
  logic        start, bound;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [N_DIGITS-1:0] bits_q, bits_d;
  logic        tick_q, tick_d;

  scan_prescaler #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_pre (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .en_i        (run_q),
    .slot_end_o  (slot_end),
    .blank_end_o (blank_end)
  );

  assign start = !run_q || slot_end;
  assign bound = run_q && slot_end && (dig_q == 2'd3);

`ifndef SCAN_BLANK_EN
  logic unused_blank;
  assign unused_blank = blank_end ^ (state_q == ST_SHOW);
`endif

  // next slot position, frame-boundary swap and output values
  always_comb begin
    dig_d  = (run_q && slot_end) ? dig_q + 2'd1 : dig_q;
    disp_d = (bound && pend_v) ? pend_q : disp_q;
`ifdef SCAN_BLANK_EN
    state_d = state_q;
    if (start)
      state_d = ST_BLANK;
    else if (state_q == ST_BLANK && blank_end)
      state_d = ST_SHOW;
`else
    state_d = ST_SHOW;
`endif
    code_d = code_sel(disp_d, dig_d);
    bits_d = (state_d == ST_SHOW) ? bits_on(dig_d) : BITS_OFF;
    tick_d = start && (dig_d == 2'd0);
  end

  // scan state, shown data and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      run_q   <= 1'b0;
      state_q <= ST_BLANK;
      dig_q   <= '0;
      disp_q  <= '0;
      code_q  <= '0;
      bits_q  <= BITS_OFF;
      tick_q  <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      dig_q   <= dig_d;
      disp_q  <= disp_d;
      code_q  <= code_d;
      bits_q  <= bits_d;
      tick_q  <= tick_d;
    end
  end

  // pending buffer: newest LOAD wins, boundary consumes it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_q <= '0;
      pend_v <= 1'b0;
    end else if (bus.LOAD) begin
      pend_q <= bus.DATA_IN;
      pend_v <= 1'b1;
    end else if (bound) begin
      pend_v <= 1'b0;
    end
  end

  assign bus.CODE_OUT   = code_q;
  assign bus.BITS       = bits_q;
  assign bus.PENDING    = pend_v;
  assign bus.FRAME_TICK = tick_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: directed bench with a time-based display model.
// Builds with or without SCAN_BLANK_EN.
module tb_display_scan_mux;

  localparam int P  = 4;
  localparam int BC = 1;
  localparam int FR = 4 * P;
`ifdef SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  display_scan_mux_if bus();

  display_scan_mux #(
    .PRESCALE     (P),
    .BLANK_CYCLES (BC)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // model: cycle index since start, shown/pending data
  int          mt = -1;
  logic [11:0] mdisp = '0;
  logic [11:0] mpend = '0;
  logic        mpv = 1'b0;

  task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h mt=%0d", nm, got, exp, mt);
    end
  endtask

  task automatic mreset();
    mt = -1;
    mdisp = '0;
    mpend = '0;
    mpv = 1'b0;
  endtask

  task automatic compare();
    int dig;
    logic [3:0] eb;
    logic [2:0] ec;
    logic et;
    if (mt < 0) begin
      eb = 4'b1111;
      ec = 3'd0;
      et = 1'b0;
    end else begin
      dig = (mt / P) % 4;
      ec = 3'((mdisp >> (3 * dig)) & 12'd7);
      eb = 4'b1111;
      if (!(BLANK && (mt % P) < BC)) eb[dig] = 1'b0;
      et = (mt % FR) == 0;
    end
    chk("bits", {12'd0, bus.BITS}, {12'd0, eb});
    chk("code", {13'd0, bus.CODE_OUT}, {13'd0, ec});
    chk("pending", {15'd0, bus.PENDING}, {15'd0, mpv});
    chk("tick", {15'd0, bus.FRAME_TICK}, {15'd0, et});
  endtask

  task automatic step();
    logic ld;
    logic [11:0] dat;
    bit bnd;
    @(posedge clk);
    if (!rst_n) begin
      mreset();
    end else begin
      ld = bus.LOAD;
      dat = bus.DATA_IN;
      bnd = (mt >= 0) && ((mt + 1) % FR == 0);
      mt++;
      if (bnd && mpv) begin
        mdisp = mpend;
        mpv = 1'b0;
      end
      if (ld) begin
        mpend = dat;
        mpv = 1'b1;
      end
    end
    #1;
    compare();
  endtask

  task automatic run_to(int target);
    int guard;
    guard = 0;
    while (mt < target && guard < 1000) begin
      step();
      guard++;
    end
    chk("run_to", 16'(mt), 16'(target));
  endtask

  task automatic load(logic [11:0] d);
    bus.LOAD = 1'b1;
    bus.DATA_IN = d;
    step();
    bus.LOAD = 1'b0;
  endtask

  initial begin
    bus.LOAD = 1'b0;
    bus.DATA_IN = '0;
    #3;
    repeat (3) step();
    chk("rst_bits", {12'd0, bus.BITS}, 16'hF);
    chk("rst_code", {13'd0, bus.CODE_OUT}, 16'h0);
    rst_n = 1'b1;

    step();
    chk("t0_tick", {15'd0, bus.FRAME_TICK}, 16'h1);
    chk("t0_bits", {12'd0, bus.BITS}, BLANK ? 16'hF : 16'hE);
    step();
    chk("t1_bits", {12'd0, bus.BITS}, 16'hE);
    chk("t1_tick", {15'd0, bus.FRAME_TICK}, 16'h0);

    run_to(5);
    load(12'o7531);
    chk("ld_pend", {15'd0, bus.PENDING}, 16'h1);
    chk("ld_old", {13'd0, bus.CODE_OUT}, 16'h0);
    run_to(16);
    chk("f1_pend", {15'd0, bus.PENDING}, 16'h0);
    chk("f1_c0", {13'd0, bus.CODE_OUT}, 16'h1);
    run_to(23);
    chk("f1_c1", {13'd0, bus.CODE_OUT}, 16'h3);
    chk("f1_b1", {12'd0, bus.BITS}, 16'hD);
    run_to(27);
    chk("f1_c2", {13'd0, bus.CODE_OUT}, 16'h5);
    chk("f1_b2", {12'd0, bus.BITS}, 16'hB);
    run_to(31);
    chk("f1_c3", {13'd0, bus.CODE_OUT}, 16'h7);
    chk("f1_b3", {12'd0, bus.BITS}, 16'h7);

    run_to(33);
    load(12'o1111);
    run_to(39);
    load(12'o2222);
    run_to(51);
    chk("ow_c0", {13'd0, bus.CODE_OUT}, 16'h2);
    run_to(63);
    chk("ow_c3", {13'd0, bus.CODE_OUT}, 16'h2);

    run_to(69);
    load(12'o3333);
    run_to(79);
    load(12'o4444);
    chk("col_c0", {13'd0, bus.CODE_OUT}, 16'h3);
    chk("col_pend", {15'd0, bus.PENDING}, 16'h1);
    run_to(95);
    chk("col_c3", {13'd0, bus.CODE_OUT}, 16'h3);
    run_to(96);
    chk("nxt_c0", {13'd0, bus.CODE_OUT}, 16'h4);
    chk("nxt_pend", {15'd0, bus.PENDING}, 16'h0);

    run_to(106);
    chk("pre_rst_b", {12'd0, bus.BITS}, 16'hB);
    #2 rst_n = 1'b0;
    #1;
    mreset();
    chk("mid_rst_b", {12'd0, bus.BITS}, 16'hF);
    chk("mid_rst_c", {13'd0, bus.CODE_OUT}, 16'h0);
    chk("mid_rst_t", {15'd0, bus.FRAME_TICK}, 16'h0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("re_c0", {13'd0, bus.CODE_OUT}, 16'h0);
    chk("re_tick", {15'd0, bus.FRAME_TICK}, 16'h1);

    run_to(20);
    load(12'o6705);
    run_to(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
